spi_adc_multi: RTL and testbench
================================

// Module: spi_adc_multi
// PURPOSE
//  Parametrised multi-channel SPI ADC reader; successor to the single-word SPI_ADC reader.
//  Each falling edge of the ADC nDRDY line starts one frame: nCS is held low while CH_N words
//  of DATA_W bits are read back-to-back, and the channel index is sent to the ADC on SDOUT.
//  Each word is presented on dataout/chan with a one-cycle drdy strobe for the logger core.
//  Adds programmable SCLK rate, channel sequencing and sticky overrun detection.
// PARAMETERS
//  DATA_W   16  bits per ADC word, 8..32
//  CH_N     4   channels read per frame, 1..16
//  CLK_DIV  2   clk cycles per SCLK half-period, >=1 (SCLK period = 2*CLK_DIV clk)
//  CH_W     localparam = max(1,$clog2(CH_N)); CH_W<=DATA_W is required
// PORTS
//  clk      in   1       system clock (10 MHz in logger)
//  res      in   1       reset, asynchronous, active-high
//  nDRDY    in   1       ADC data-ready, active-low, asynchronous to clk
//  SDIN     in   1       serial data from ADC (MISO)
//  ovr_clr  in   1       clears the ovr flag
//  SDOUT    out  1       serial command to ADC (MOSI)
//  SCLK     out  1       SPI clock, idle low
//  nCS      out  1       ADC chip select, active-low
//  drdy     out  1       one-clk strobe: dataout/chan updated
//  dataout  out  DATA_W  last received word, MSB-first assembled
//  chan     out  CH_W    channel index of dataout
//  busy     out  1       frame in progress (state != IDLE)
//  ovr      out  1       sticky: nDRDY fell while busy
// BEHAVIOUR
//  Reset (async, immediate): nCS=1, SCLK=0, SDOUT=0, drdy=0, dataout=0, chan=0, busy=0, ovr=0;
//   sync/edge flops preset to 1 (no false edge out of reset); state=IDLE, channel counter=0.
//  nDRDY: 3-flop chain (2 sync + 1 delay); fall = s2==0 && s3==1. nCS goes low on the 3rd
//   rising clk edge after the first edge that samples nDRDY low. Pulses shorter than 1 clk may be missed.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
//   IDLE : nCS=1, SCLK=0; on fall -> SETUP, ch=0.
//   SETUP: nCS=0, SCLK=0 for CLK_DIV cycles -> SHIFT.
//   SHIFT: per bit, SCLK low CLK_DIV cycles, then high CLK_DIV cycles. SDOUT changes only while
//    SCLK low; SDIN is sampled on the clk edge where SCLK goes 0->1. MSB first.
//    SDOUT for channel k: bits 0..CH_W-1 carry k MSB-first, remaining bits 0.
//    After bit DATA_W-1 high phase: dataout<=word, chan<=k, drdy=1 for exactly 1 clk.
//    If k<CH_N-1: k++, continue SHIFT without gap (nCS stays low); else -> HOLD.
//   HOLD : SCLK=0, nCS=0 for CLK_DIV cycles, then nCS=1 -> IDLE. A new fall is accepted the
//    first cycle in IDLE.
//  Frame length (nCS low) = CLK_DIV*(2 + 2*DATA_W*CH_N) clk; defaults: 260 clk = 26 us.
//  Exactly DATA_W*CH_N SCLK rising edges per frame; dataout/chan hold between strobes.
//  Overrun: fall detected in any state != IDLE -> ovr<=1, event dropped, current frame
//   unaffected. ovr_clr clears ovr; simultaneous set and clear -> ovr stays 1.
//  Reset mid-frame: outputs return to reset values immediately; partial word discarded, no drdy.
// TESTING
//  1 res pulse 100 ns -> all outputs at reset values; no nCS activity while nDRDY stays 1.
//  2 defaults, SDIN=1, nDRDY low 200 ns -> 4 drdy strobes, dataout=16'hFFFF, chan=0,1,2,3;
//    64 SCLK rises; nCS low 260 clk; busy matches nCS low window.
//  3 slave model returns 16'hA5C0+k on ch k -> dataout=A5C0..A5C3; slave sees SDOUT word k<<14.
//  4 2nd nDRDY fall 50 clk into frame -> ovr=1, still 4 strobes, no 2nd frame; ovr_clr -> 0;
//    clr in same cycle as new overrun -> ovr=1.
//  5 res asserted during ch 2 bit 5 -> nCS=1, SCLK=0 at once, no drdy; next fall reads ch 0 first.
//  6 CH_N=1, DATA_W=24, CLK_DIV=1, slave 24'h123456 -> one strobe, dataout=24'h123456,
//    chan=0, SCLK period 2 clk, nCS low 50 clk.

Source files
------------

// File: rtl/spi_adc_multi.sv
// Multi-channel SPI ADC frame reader: one frame of CH_N words per nDRDY falling edge,
// channel index sent on SDOUT, each received word strobed out on drdy with its channel.
module spi_adc_multi #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CH_N    = 4,
    parameter int unsigned CLK_DIV = 2,
    localparam int unsigned CH_W   = (CH_N > 1) ? $clog2(CH_N) : 1
) (
    input  logic              clk,
    input  logic              res,
    input  logic              nDRDY,
    input  logic              SDIN,
    input  logic              ovr_clr,
    output logic              SDOUT,
    output logic              SCLK,
    output logic              nCS,
    output logic              drdy,
    output logic [DATA_W-1:0] dataout,
    output logic [CH_W-1:0]   chan,
    output logic              busy,
    output logic              ovr
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   div_cnt, div_n;
    logic               hi, hi_n;
    logic [BIT_W-1:0]   bit_cnt, bit_n;
    logic [CH_W-1:0]    ch, ch_n;
    logic [DATA_W-1:0]  shreg;
    logic [DATA_W-1:0]  word_c;
    logic [DATA_W-1:0]  cmd_c;
    logic               s1, s2, s3;
    logic               fall_c, div_done_c, sample_c, word_done_c, sclk_c, sdout_c;

    // nDRDY synchroniser plus delay flop; preset high so reset release never looks like a fall
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= nDRDY;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall_c     = ~s2 & s3;
    assign div_done_c = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign sclk_c     = (state == SHIFT) & hi;
    assign sample_c   = (state == SHIFT) & hi & (div_cnt == '0);
    assign word_c     = sample_c ? {shreg[DATA_W-2:0], SDIN} : shreg;
    assign cmd_c      = DATA_W'(ch) << (DATA_W - CH_W);
    assign sdout_c    = ((state == SETUP) || (state == SHIFT)) ?
                        cmd_c[BIT_W'(DATA_W - 1) - bit_cnt] : 1'b0;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state   <= IDLE;
            div_cnt <= '0;
            hi      <= 1'b0;
            bit_cnt <= '0;
            ch      <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            hi      <= hi_n;
            bit_cnt <= bit_n;
            ch      <= ch_n;
            shreg   <= word_c;
        end
    end

    always_comb begin
        state_n     = state;
        div_n       = div_cnt;
        hi_n        = hi;
        bit_n       = bit_cnt;
        ch_n        = ch;
        word_done_c = 1'b0;
        case (state)
            IDLE: begin
                if (fall_c) begin
                    state_n = SETUP;
                    div_n   = '0;
                    hi_n    = 1'b0;
                    bit_n   = '0;
                    ch_n    = '0;
                end
            end
            SETUP: begin
                if (div_done_c) begin
                    state_n = SHIFT;
                    div_n   = '0;
                    hi_n    = 1'b0;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (!div_done_c) begin
                    div_n = div_cnt + DIV_W'(1);
                end else begin
                    div_n = '0;
                    hi_n  = ~hi;
                    // end of a high phase closes one bit; last bit closes the word
                    if (hi) begin
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            word_done_c = 1'b1;
                            bit_n       = '0;
                            if (ch == CH_W'(CH_N - 1)) begin
                                state_n = HOLD;
                            end else begin
                                ch_n = ch + CH_W'(1);
                            end
                        end else begin
                            bit_n = bit_cnt + BIT_W'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (div_done_c) begin
                    state_n = IDLE;
                    div_n   = '0;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered pin outputs follow the state one clock later, so nCS and busy share one window
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            nCS     <= 1'b1;
            SCLK    <= 1'b0;
            SDOUT   <= 1'b0;
            drdy    <= 1'b0;
            dataout <= '0;
            chan    <= '0;
            busy    <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            nCS   <= (state == IDLE);
            SCLK  <= sclk_c;
            SDOUT <= sdout_c;
            drdy  <= word_done_c;
            busy  <= (state != IDLE);
            if (word_done_c) begin
                dataout <= word_c;
                chan    <= ch;
            end
            if (fall_c && (state != IDLE)) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_adc_multi.sv
// Bench for spi_adc_multi: two instances (default and 24-bit/1-ch/div-1) driven by SPI slave models.
module tb_spi_adc_multi;

    localparam int unsigned A_DW = 16, A_CH = 4, A_DIV = 2, A_CHW = 2;
    localparam int unsigned B_DW = 24, B_CH = 1, B_DIV = 1, B_CHW = 1;
    localparam int unsigned A_FRAME = A_DIV * (2 + 2 * A_DW * A_CH);
    localparam int unsigned B_FRAME = B_DIV * (2 + 2 * B_DW * B_CH);

    logic clk = 1'b0;
    logic res = 1'b0;
    always #50 clk = ~clk;

    logic            a_ndrdy = 1'b1, a_sdin = 1'b0, a_clr = 1'b0;
    logic            a_sdout, a_sclk, a_ncs, a_drdy, a_busy, a_ovr;
    logic [A_DW-1:0] a_dout;
    logic [A_CHW-1:0] a_chan;

    logic            b_ndrdy = 1'b1, b_sdin = 1'b0, b_clr = 1'b0;
    logic            b_sdout, b_sclk, b_ncs, b_drdy, b_busy, b_ovr;
    logic [B_DW-1:0] b_dout;
    logic [B_CHW-1:0] b_chan;

    spi_adc_multi #(.DATA_W(A_DW), .CH_N(A_CH), .CLK_DIV(A_DIV)) dut_a (
        .clk(clk), .res(res), .nDRDY(a_ndrdy), .SDIN(a_sdin), .ovr_clr(a_clr),
        .SDOUT(a_sdout), .SCLK(a_sclk), .nCS(a_ncs), .drdy(a_drdy),
        .dataout(a_dout), .chan(a_chan), .busy(a_busy), .ovr(a_ovr));

    spi_adc_multi #(.DATA_W(B_DW), .CH_N(B_CH), .CLK_DIV(B_DIV)) dut_b (
        .clk(clk), .res(res), .nDRDY(b_ndrdy), .SDIN(b_sdin), .ovr_clr(b_clr),
        .SDOUT(b_sdout), .SCLK(b_sclk), .nCS(b_ncs), .drdy(b_drdy),
        .dataout(b_dout), .chan(b_chan), .busy(b_busy), .ovr(b_ovr));

    int checks = 0;
    int errors = 0;

    // ---- slave A: mode-0 ADC, words a_word[k] returned MSB-first, MOSI captured per channel
    logic [A_DW-1:0] a_word [A_CH];
    logic [A_DW-1:0] a_mosi [A_CH];
    int   a_bit = 0, a_rises = 0;
    logic a_sclk_q = 1'b0;
    always @(negedge a_ncs or a_sclk) begin
        if (a_sclk !== a_sclk_q) begin
            a_sclk_q = a_sclk;
            if (a_sclk === 1'b1) begin
                if (a_bit < A_DW * A_CH) a_mosi[a_bit / A_DW][A_DW - 1 - (a_bit % A_DW)] = a_sdout;
                a_bit++;
                a_rises++;
            end else if (a_ncs === 1'b0 && a_bit < A_DW * A_CH) begin
                a_sdin = a_word[a_bit / A_DW][A_DW - 1 - (a_bit % A_DW)];
            end
        end else if (a_ncs === 1'b0) begin
            a_bit = 0;
            for (int k = 0; k < A_CH; k++) a_mosi[k] = '0;
            a_sdin = a_word[0][A_DW-1];
        end
    end

    // ---- slave B
    logic [B_DW-1:0] b_word = '0;
    logic [B_DW-1:0] b_mosi = '0;
    int   b_bit = 0, b_rises = 0;
    logic b_sclk_q = 1'b0;
    always @(negedge b_ncs or b_sclk) begin
        if (b_sclk !== b_sclk_q) begin
            b_sclk_q = b_sclk;
            if (b_sclk === 1'b1) begin
                if (b_bit < B_DW) b_mosi[B_DW - 1 - b_bit] = b_sdout;
                b_bit++;
                b_rises++;
            end else if (b_ncs === 1'b0 && b_bit < B_DW) begin
                b_sdin = b_word[B_DW - 1 - b_bit];
            end
        end else if (b_ncs === 1'b0) begin
            b_bit  = 0;
            b_mosi = '0;
            b_sdin = b_word[B_DW-1];
        end
    end

    // ---- monitors sampled on the falling clk edge
    logic [A_DW-1:0]  a_cap_d [256];
    logic [A_CHW-1:0] a_cap_c [256];
    int a_strobes = 0, a_ncs_low = 0, a_ncs_falls = 0, a_busy_bad = 0, a_sdout_bad = 0;
    logic a_ncs_p = 1'b1, a_sclk_p = 1'b0, a_sdout_p = 1'b0;
    always @(negedge clk) begin
        if (a_drdy === 1'b1) begin
            if (a_strobes < 256) begin
                a_cap_d[a_strobes] = a_dout;
                a_cap_c[a_strobes] = a_chan;
            end
            a_strobes++;
        end
        if (a_ncs === 1'b0) a_ncs_low++;
        if (a_ncs === 1'b0 && a_ncs_p === 1'b1) a_ncs_falls++;
        if (a_busy !== ~a_ncs) a_busy_bad++;
        if (a_sclk === 1'b1 && a_sclk_p === 1'b1 && a_sdout !== a_sdout_p) a_sdout_bad++;
        a_ncs_p = a_ncs; a_sclk_p = a_sclk; a_sdout_p = a_sdout;
    end

    logic [B_DW-1:0] b_cap_d = '0;
    logic [B_CHW-1:0] b_cap_c = '0;
    int b_strobes = 0, b_ncs_low = 0, b_per_bad = 0, b_cyc = 0, b_last = -1;
    logic b_sclk_p = 1'b0;
    always @(negedge clk) begin
        b_cyc++;
        if (b_drdy === 1'b1) begin
            b_cap_d = b_dout;
            b_cap_c = b_chan;
            b_strobes++;
        end
        if (b_ncs === 1'b0) b_ncs_low++;
        if (b_ncs !== 1'b0) b_last = -1;
        else if (b_sclk === 1'b1 && b_sclk_p === 1'b0) begin
            if (b_last >= 0 && (b_cyc - b_last) != 2) b_per_bad++;
            b_last = b_cyc;
        end
        b_sclk_p = b_sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // nDRDY low for 2 clk, launched at a falling clk edge
    task automatic start_a();
        @(negedge clk) a_ndrdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) a_ndrdy = 1'b1;
    endtask

    task automatic start_b();
        @(negedge clk) b_ndrdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) b_ndrdy = 1'b1;
    endtask

    task automatic wait_a_idle(input string tag);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 600 && a_busy === 1'b1; i++) @(negedge clk);
        chk(tag, 32'(a_busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // full-frame checks against the slave word table and the channel-index command rule
    task automatic check_a_frame(input string tag, input int sb, input int rb, input int lb);
        chk({tag, "_strobes"}, 32'(a_strobes - sb), 32'd4);
        chk({tag, "_rises"}, 32'(a_rises - rb), 32'(A_DW * A_CH));
        chk({tag, "_ncs_low"}, 32'(a_ncs_low - lb), 32'(A_FRAME));
        for (int k = 0; k < A_CH; k++) begin
            chk({tag, "_data"}, 32'(a_cap_d[sb + k]), 32'(a_word[k]));
            chk({tag, "_chan"}, 32'(a_cap_c[sb + k]), 32'(k));
            chk({tag, "_mosi"}, 32'(a_mosi[k]), 32'(k) << (A_DW - A_CHW));
        end
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sb, rb, lb, fb;

        // 1: reset pulse
        for (int k = 0; k < A_CH; k++) a_word[k] = '0;
        #20 res = 1'b1;
        #90;
        chk("rst_a_ctl", 32'({a_ncs, a_sclk, a_sdout, a_drdy, a_busy, a_ovr}), 32'b100000);
        chk("rst_a_data", 32'({a_dout, a_chan}), 32'd0);
        chk("rst_b_ctl", 32'({b_ncs, b_sclk, b_sdout, b_drdy, b_busy, b_ovr}), 32'b100000);
        chk("rst_b_data", 32'({b_dout, b_chan}), 32'd0);
        #10 res = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_no_ncs", 32'(a_ncs_falls), 32'd0);
        chk("idle_ncs_hi", 32'(a_ncs & b_ncs), 32'd1);

        // 2: all-ones frame, with start latency measured from the first sampling edge
        for (int k = 0; k < A_CH; k++) a_word[k] = 16'hFFFF;
        sb = a_strobes; rb = a_rises; lb = a_ncs_low;
        @(negedge clk) a_ndrdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) a_ndrdy = 1'b1;
        @(posedge clk);
        #1 chk("lat_edge2", 32'(a_ncs), 32'd1);
        @(posedge clk);
        #1 chk("lat_edge3", 32'(a_ncs), 32'd0);
        wait_a_idle("ones_done");
        check_a_frame("ones", sb, rb, lb);

        // 3: directed then random slave words
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < A_CH; k++)
                a_word[k] = (r == 0) ? 16'(16'hA5C0 + k) : 16'($urandom);
            sb = a_strobes; rb = a_rises; lb = a_ncs_low;
            start_a();
            wait_a_idle("rnd_done");
            check_a_frame("rnd", sb, rb, lb);
        end

        // 4: overrun mid-frame, clear, then clear colliding with a new overrun
        for (int k = 0; k < A_CH; k++) a_word[k] = 16'($urandom);
        sb = a_strobes; rb = a_rises; lb = a_ncs_low; fb = a_ncs_falls;
        start_a();
        repeat (50) @(negedge clk);
        chk("ovr_pre", 32'(a_ovr), 32'd0);
        a_ndrdy = 1'b0;
        repeat (2) @(negedge clk);
        a_ndrdy = 1'b1;
        wait_a_idle("ovr_done");
        repeat (20) @(negedge clk);
        chk("ovr_set", 32'(a_ovr), 32'd1);
        chk("ovr_one_frame", 32'(a_ncs_falls - fb), 32'd1);
        check_a_frame("ovr", sb, rb, lb);
        a_clr = 1'b1;
        @(negedge clk) a_clr = 1'b0;
        chk("ovr_clr", 32'(a_ovr), 32'd0);

        sb = a_strobes; rb = a_rises; lb = a_ncs_low;
        start_a();
        repeat (50) @(negedge clk);
        a_ndrdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("ovr_coll_pre", 32'(a_ovr), 32'd0);
        a_clr = 1'b1;
        a_ndrdy = 1'b1;
        @(negedge clk) a_clr = 1'b0;
        chk("ovr_coll", 32'(a_ovr), 32'd1);
        wait_a_idle("coll_done");
        check_a_frame("coll", sb, rb, lb);

        // 5: reset in channel 2 bit 5, then a clean frame starting at channel 0
        for (int k = 0; k < A_CH; k++) a_word[k] = 16'($urandom);
        sb = a_strobes; rb = a_rises;
        start_a();
        for (int i = 0; i < 600 && (a_rises - rb) < (2 * A_DW + 6); i++) @(negedge clk);
        chk("mid_point", 32'(a_rises - rb), 32'(2 * A_DW + 6));
        res = 1'b1;
        #1;
        chk("mid_rst_ctl", 32'({a_ncs, a_sclk, a_drdy, a_busy, a_ovr}), 32'b10000);
        chk("mid_rst_strobes", 32'(a_strobes - sb), 32'd2);
        @(negedge clk) res = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_no_drdy", 32'(a_strobes - sb), 32'd2);
        for (int k = 0; k < A_CH; k++) a_word[k] = 16'($urandom);
        sb = a_strobes; rb = a_rises; lb = a_ncs_low;
        start_a();
        wait_a_idle("post_rst_done");
        check_a_frame("post_rst", sb, rb, lb);

        // 6: 24-bit, single channel, fastest SCLK
        for (int r = 0; r < 2; r++) begin
            b_word = (r == 0) ? 24'h123456 : 24'($urandom);
            sb = b_strobes; rb = b_rises; lb = b_ncs_low;
            start_b();
            repeat (3) @(negedge clk);
            for (int i = 0; i < 200 && b_busy === 1'b1; i++) @(negedge clk);
            chk("b_done", 32'(b_busy), 32'd0);
            repeat (4) @(negedge clk);
            chk("b_strobes", 32'(b_strobes - sb), 32'd1);
            chk("b_data", 32'(b_cap_d), 32'(b_word));
            chk("b_chan", 32'(b_cap_c), 32'd0);
            chk("b_rises", 32'(b_rises - rb), 32'(B_DW));
            chk("b_ncs_low", 32'(b_ncs_low - lb), 32'(B_FRAME));
            chk("b_mosi", 32'(b_mosi), 32'd0);
        end
        chk("b_period", 32'(b_per_bad), 32'd0);
        chk("a_busy_window", 32'(a_busy_bad), 32'd0);
        chk("a_sdout_stable", 32'(a_sdout_bad), 32'd0);
        chk("b_ovr", 32'(b_ovr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
